// File: rtl/psum_ofifo_pkg.sv
// Shared sizing constants for the partial-sum output FIFO.
package psum_ofifo_pkg;
  localparam int COL         = 8;
  localparam int BW_PSUM     = 22;
  localparam int OFIFO_DEPTH = 16;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH);
endpackage

// File: rtl/ofifo_col.sv
// Single-lane FIFO: one MAC column's partial sums, sticky drop flag on overflow.
module ofifo_col
  import psum_ofifo_pkg::*;
#(
  parameter int bw_psum = BW_PSUM,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [bw_psum-1:0] in,
  output logic [bw_psum-1:0] out,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow
);
  localparam int ptr_w = $clog2(depth);

  logic [bw_psum-1:0] mem [depth];
  logic [ptr_w-1:0]   wptr;
  logic [ptr_w-1:0]   rptr;
  logic [ptr_w:0]     count;
  logic               wr_acc;

  always_comb begin
    o_empty = (count == '0);
    o_full  = (count == (ptr_w+1)'(depth));
    // rd is only asserted when this lane is non-empty, so a full lane can
    // take a write in the same cycle it gives up its head entry.
    wr_acc  = wr & (~o_full | rd);
    out     = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ptr_w'(1);
      if (rd)     rptr <= rptr + ptr_w'(1);
      case ({wr_acc, rd})
        2'b10:   count <= count + (ptr_w+1)'(1);
        2'b01:   count <= count - (ptr_w+1)'(1);
        default: count <= count;
      endcase
      if (wr & ~wr_acc) o_overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/psum_ofifo.sv
// Per-column output FIFO for MAC partial sums; releases a row only when every column holds data.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [col-1:0]         o_overflow
);
  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col*bw_psum-1:0] head_row;
  logic                   rd_acc;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofifo_col #(
      .bw_psum (bw_psum),
      .depth   (depth)
    ) u_col (
      .clk        (clk),
      .reset      (reset),
      .wr         (wr[i]),
      .rd         (rd_acc),
      .in         (in[bw_psum*i +: bw_psum]),
      .out        (head_row[bw_psum*i +: bw_psum]),
      .o_empty    (empty[i]),
      .o_full     (full[i]),
      .o_overflow (o_overflow[i])
    );
  end

  always_comb begin
    o_valid = ~|empty;
    o_full  = |full;
    rd_acc  = rd & o_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)       out <= '0;
    else if (rd_acc) out <= head_row;
  end
endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo with hand-computed expected rows.
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int W = COL * BW_PSUM;

  logic           clk = 1'b0;
  logic           reset;
  logic [COL-1:0] wr;
  logic [W-1:0]   in_d;
  logic           rd;
  logic [W-1:0]   out_q;
  logic           o_valid;
  logic           o_full;
  logic [COL-1:0] o_overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [W-1:0] exp_row;
  logic [W-1:0] held_row;

  psum_ofifo #(
    .col     (COL),
    .bw_psum (BW_PSUM),
    .depth   (OFIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .in         (in_d),
    .rd         (rd),
    .out        (out_q),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int unsigned lane, input int unsigned val);
    in_d[lane*BW_PSUM +: BW_PSUM] = BW_PSUM'(val);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr    = '0;
    rd    = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr    = '0;
    rd    = 1'b0;
    in_d  = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_full", W'(o_full), W'(0));
    check("rst_ovf", W'(o_overflow), W'(0));
    check("rst_out", out_q, '0);

    // Skewed writes: lane i gets 100+i on cycle i
    for (int i = 0; i < COL; i++) begin
      wr = '0;
      wr[i] = 1'b1;
      set_lane(i, 100 + i);
      tick();
      check($sformatf("skew_valid_%0d", i), W'(o_valid), W'(i == COL - 1));
    end
    wr = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < COL; i++) exp_row[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(100 + i);
    check("skew_out", out_q, exp_row);
    check("skew_valid_after", W'(o_valid), W'(0));
    held_row = exp_row;

    // Ignored read with lane 7 empty
    wr = 8'h7F;
    for (int i = 0; i < COL; i++) set_lane(i, 200 + i);
    tick();
    wr = '0;
    check("ign_valid", W'(o_valid), W'(0));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("ign_out", out_q, held_row);
    wr = 8'h80;
    tick();
    wr = '0;
    check("ign_valid_l7", W'(o_valid), W'(1));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < COL; i++) exp_row[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(200 + i);
    check("ign_out_row", out_q, exp_row);
    check("ign_valid_after", W'(o_valid), W'(0));

    // Full lane 3 with simultaneous write and accepted read
    wr = 8'hFF;
    for (int i = 0; i < COL; i++) set_lane(i, 300);
    tick();
    for (int k = 1; k < OFIFO_DEPTH; k++) begin
      wr = 8'h08;
      set_lane(3, 300 + k);
      tick();
    end
    check("wrrd_full_pre", W'(o_full), W'(1));
    wr = 8'h08;
    set_lane(3, 316);
    rd = 1'b1;
    tick();
    wr = '0;
    rd = 1'b0;
    for (int i = 0; i < COL; i++) exp_row[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(300);
    check("wrrd_out", out_q, exp_row);
    check("wrrd_full", W'(o_full), W'(1));
    check("wrrd_ovf", W'(o_overflow), W'(0));
    wr = 8'hF7;
    for (int i = 0; i < COL; i++) set_lane(i, 400);
    tick();
    wr = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < COL; i++) exp_row[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(i == 3 ? 301 : 400);
    check("wrrd_next_head", out_q, exp_row);
    do_reset();
    tick();

    // Overflow on lane 3, then drain in order
    for (int k = 0; k < OFIFO_DEPTH; k++) begin
      wr = 8'h08;
      set_lane(3, k);
      tick();
    end
    check("ovf_full", W'(o_full), W'(1));
    check("ovf_none_yet", W'(o_overflow), W'(0));
    set_lane(3, 99);
    tick();
    check("ovf_set", W'(o_overflow), W'(8'h08));
    check("ovf_full2", W'(o_full), W'(1));
    for (int k = 0; k < OFIFO_DEPTH; k++) begin
      wr = 8'hF7;
      for (int i = 0; i < COL; i++) if (i != 3) set_lane(i, 500 + k);
      tick();
    end
    wr = '0;
    rd = 1'b1;
    for (int k = 0; k < OFIFO_DEPTH; k++) begin
      tick();
      for (int i = 0; i < COL; i++) exp_row[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(i == 3 ? k : 500 + k);
      check($sformatf("drain_%0d", k), out_q, exp_row);
    end
    rd = 1'b0;
    check("drain_valid", W'(o_valid), W'(0));
    check("drain_full", W'(o_full), W'(0));
    check("ovf_sticky", W'(o_overflow), W'(8'h08));

    // Mid-stream reset with 5 rows buffered
    for (int r = 0; r < 5; r++) begin
      wr = 8'hFF;
      for (int i = 0; i < COL; i++) set_lane(i, 600 + r);
      tick();
    end
    wr = '0;
    check("mid_valid_pre", W'(o_valid), W'(1));
    do_reset();
    check("mid_valid", W'(o_valid), W'(0));
    check("mid_out", out_q, '0);
    check("mid_ovf", W'(o_overflow), W'(0));
    check("mid_full", W'(o_full), W'(0));
    wr = 8'hFF;
    for (int i = 0; i < COL; i++) set_lane(i, 700 + i);
    tick();
    wr = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < COL; i++) exp_row[i*BW_PSUM +: BW_PSUM] = BW_PSUM'(700 + i);
    check("post_rst_row", out_q, exp_row);
    check("post_rst_valid", W'(o_valid), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output FIFO that collects partial sums from the MAC array, one independent queue per column. Columns finish at staggered cycles (the array's `fifo_wr` strobes skew across columns). The block therefore buffers each column separately and presents a complete row only when every column holds data. It sits directly downstream of the MAC array and upstream of the psum SRAM write path / accumulation logic.

## Interface
Parameters:
- `col`, 8, number of MAC columns / FIFO lanes
- `bw_psum`, 22, partial-sum width per column
- `depth`, 16, entries per column; power of 2, ≥ 2

Ports:
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `wr`  in  col  per-column write strobe, driven by MAC array `fifo_wr`
- `in`  in  col*bw_psum  column data; lane i = `in[bw_psum*(i+1)-1 : bw_psum*i]`
- `rd`  in  1  pop one row from all columns
- `out`  out  col*bw_psum  registered last-popped row, same lane packing as `in`
- `o_valid`  out  1  every column non-empty
- `o_full`  out  1  at least one column full
- `o_overflow`  out  col  sticky per-column drop flag

## Operation
- Each lane has its own state:
  - write pointer and read pointer, each log2(depth) bits, wrapping modulo depth
  - count, log2(depth)+1 bits, range 0..depth
- `o_valid` = AND over lanes of (count ≠ 0). Combinational from current state.
- `o_full` = OR over lanes of (count == depth). Combinational from current state.
- Read accept: `rd_acc = rd & o_valid`.
  - If `rd` is high while `o_valid` is low, it is ignored. No pointer moves, `out` holds.
  - On `rd_acc`, every lane pops exactly one entry (head row) and `out` loads that row.
- Write accept for lane i: `wr_acc[i] = wr[i] & (count_i < depth | rd_acc)`.
  - A full lane accepts a write only when a read is accepted in the same cycle.
  - If `wr[i]` is high and lane i is full with no accepted read, the data is dropped, the pointers are unchanged, and `o_overflow[i]` is set. The flag stays set until reset.
- Count update per lane: +1 on write-only, −1 on read-only, unchanged on write + read.
- Empty lane with `wr` and `rd` in the same cycle: `o_valid` is 0, so the read is not accepted and the write proceeds normally.
- Writes never reorder within a lane. Lanes never couple except through the shared `rd_acc`.
- Reset, including mid-operation, clears all pointers, counts, `out` and `o_overflow`. Any buffered data is discarded.

## Timing
- Write at edge N: lane count reflects it after N. `o_valid` can rise in the cycle after the last missing lane's write.
- Accepted read at edge N: `out` shows the popped row after N (1-cycle latency from `rd` to data). Counts and `o_valid`/`o_full` update after the same edge.
- Back-to-back reads are allowed every cycle while `o_valid` is high. Throughput is 1 row/cycle.
- Reset values:
  - `out` = 0
  - `o_valid` = 0
  - `o_full` = 0
  - `o_overflow` = 0
- Storage needs no reset. Reading unwritten storage is impossible by construction.

## Structure
- Shared package holds:
  - `COL` = 8
  - `BW_PSUM` = 22
  - `OFIFO_DEPTH` = 16
  - `OFIFO_PTR_W` = log2(`OFIFO_DEPTH`)
- One sub-module, `ofifo_col`: a single-lane FIFO.
  - Ports: `clk`, `reset`, `wr`, `rd`, `in`, `out` (head data, combinational), `o_empty`, `o_full`, `o_overflow`.
  - `psum_ofifo` instantiates `col` copies in a generate loop.
  - The top level computes `rd_acc`, feeds it to all lanes, and registers `out`.

## Test plan
- Reset, then idle: `o_valid`=0, `o_full`=0, `o_overflow`=0, `out`=0.
- Skewed writes: lane i writes `in` = 100+i at cycle i, i=0..7. `o_valid` stays 0 until the cycle after lane 7's write. Then `rd` → next cycle `out` lanes = 100..107 and `o_valid`=0.
- Ignored read: `rd` pulsed with only lanes 0..6 written → `out` unchanged, lane counts unchanged.
- Fill lane 3 with 16 writes (values 0..15), then a 17th write (value 99) with no read → `o_full`=1, `o_overflow[3]`=1 (sticky). After filling the other lanes, 16 reads return lane 3 values 0..15 in order; 99 never appears.
- Full lane 3 + `wr[3]` + accepted `rd` in the same cycle → write accepted, lane 3 count stays 16, no overflow.
- Reset asserted mid-stream with 5 rows buffered → next cycle `o_valid`=0, `out`=0, `o_overflow`=0. A subsequent single full row reads back correctly.
